// File: rtl/cplx_dot_pkg.sv
// Shared types and sizing helpers for the streaming complex dot-product engine.
package cplx_dot_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      DRAIN  = 2'd2,
      OUTPUT = 2'd3
   } state_e;

   localparam logic CONJ_OFF = 1'b0;
   localparam logic CONJ_ON  = 1'b1;

   // Worst-case growth: product (2*DATA_W), re/im add (+1), sign headroom (+1), lane and beat sums.
   function automatic int acc_width(int data_w, int lanes, int max_beats);
      return 2 * data_w + 2 + $clog2(lanes) + $clog2(max_beats);
   endfunction

endpackage

// File: rtl/cplx_mul_lane.sv
// One lane of the complex multiplier: full-precision a*b or a*conj(b), no rounding.
module cplx_mul_lane
   import cplx_dot_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic signed [DATA_W-1:0] a_re_i,
   input  logic signed [DATA_W-1:0] a_im_i,
   input  logic signed [DATA_W-1:0] b_re_i,
   input  logic signed [DATA_W-1:0] b_im_i,
   input  logic                     conj_i,
   output logic signed [2*DATA_W:0] prod_re_o,
   output logic signed [2*DATA_W:0] prod_im_o
);

   localparam int MW = 2 * DATA_W;
   localparam int PW = 2 * DATA_W + 1;

   logic signed [MW-1:0] p_rr, p_ii, p_ri, p_ir;

   assign p_rr = MW'(a_re_i) * MW'(b_re_i);
   assign p_ii = MW'(a_im_i) * MW'(b_im_i);
   assign p_ri = MW'(a_re_i) * MW'(b_im_i);
   assign p_ir = MW'(a_im_i) * MW'(b_re_i);

   always_comb begin
      if (conj_i == CONJ_ON) begin
         prod_re_o = PW'(p_rr) + PW'(p_ii);
         prod_im_o = PW'(p_ir) - PW'(p_ri);
      end else begin
         prod_re_o = PW'(p_rr) - PW'(p_ii);
         prod_im_o = PW'(p_ri) + PW'(p_ir);
      end
   end

endmodule

// File: rtl/cplx_dot_stream.sv
// Streaming complex dot-product: LANES pairs per beat, accumulated over a latched
// number of beats, one full-precision result per vector over a valid/ready port.
module cplx_dot_stream
   import cplx_dot_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int LANES     = 4,
   parameter int MAX_BEATS = 64,
   parameter int LEN_W     = $clog2(MAX_BEATS + 1),
   parameter int ACC_W     = acc_width(DATA_W, LANES, MAX_BEATS)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    flush_i,
   input  logic [LEN_W-1:0]        cfg_len_i,
   input  logic                    cfg_conj_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [LANES*DATA_W-1:0] a_re_i,
   input  logic [LANES*DATA_W-1:0] a_im_i,
   input  logic [LANES*DATA_W-1:0] b_re_i,
   input  logic [LANES*DATA_W-1:0] b_im_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [ACC_W-1:0]        result_re_o,
   output logic [ACC_W-1:0]        result_im_o,
   output logic                    busy_o
);

   localparam int PW = 2 * DATA_W + 1;

   state_e                   state_q, state_d;
   logic [LEN_W-1:0]         len_q, len_d;
   logic [LEN_W-1:0]         cnt_q, cnt_d;
   logic                     conj_q, conj_d;
   logic                     s1_valid_q, s1_valid_d;
   logic                     s1_first_q, s1_first_d;
   logic                     s1_last_q, s1_last_d;
   logic                     s2_last_q, s2_last_d;
   logic                     out_valid_q, out_valid_d;
   logic signed [ACC_W-1:0]  acc_re_q, acc_re_d, acc_im_q, acc_im_d;
   logic signed [ACC_W-1:0]  res_re_q, res_re_d, res_im_q, res_im_d;
   logic signed [PW-1:0]     lane_re [LANES];
   logic signed [PW-1:0]     lane_im [LANES];
   logic signed [PW-1:0]     s1_re_q [LANES];
   logic signed [PW-1:0]     s1_im_q [LANES];
   logic signed [ACC_W-1:0]  sum_re, sum_im;
   logic                     accept;
   logic                     conj_sel;
   logic [LEN_W-1:0]         len_eff;
   logic [LEN_W-1:0]         cnt_inc;

   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      if (len == '0)                    return LEN_W'(1);
      else if (len > LEN_W'(MAX_BEATS)) return LEN_W'(MAX_BEATS);
      else                              return len;
   endfunction

   assign in_ready_o  = (state_q == IDLE) || (state_q == ACCUM);
   assign accept      = in_valid_i && in_ready_o && !flush_i;
   assign busy_o      = (state_q != IDLE);
   assign out_valid_o = out_valid_q;
   assign result_re_o = res_re_q;
   assign result_im_o = res_im_q;

   // The first beat uses the live config; later beats use what was latched with it.
   assign conj_sel = (state_q == IDLE) ? cfg_conj_i : conj_q;
   assign len_eff  = clamp_len(cfg_len_i);
   assign cnt_inc  = cnt_q + LEN_W'(1);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      cplx_mul_lane #(.DATA_W(DATA_W)) u_lane (
         .a_re_i    (a_re_i[l*DATA_W +: DATA_W]),
         .a_im_i    (a_im_i[l*DATA_W +: DATA_W]),
         .b_re_i    (b_re_i[l*DATA_W +: DATA_W]),
         .b_im_i    (b_im_i[l*DATA_W +: DATA_W]),
         .conj_i    (conj_sel),
         .prod_re_o (lane_re[l]),
         .prod_im_o (lane_im[l])
      );
   end

   always_comb begin
      sum_re = '0;
      sum_im = '0;
      for (int l = 0; l < LANES; l++) begin
         sum_re = sum_re + ACC_W'(s1_re_q[l]);
         sum_im = sum_im + ACC_W'(s1_im_q[l]);
      end
   end

   always_comb begin
      // NOTE: every next-state signal gets a default first, so no path can infer a latch.
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      conj_d      = conj_q;
      s1_valid_d  = 1'b0;
      s1_first_d  = 1'b0;
      s1_last_d   = 1'b0;
      s2_last_d   = s1_valid_q && s1_last_q;
      out_valid_d = out_valid_q;
      acc_re_d    = acc_re_q;
      acc_im_d    = acc_im_q;
      res_re_d    = res_re_q;
      res_im_d    = res_im_q;

      // S2: the first beat of a vector restarts the sum from zero.
      if (s1_valid_q) begin
         acc_re_d = (s1_first_q ? '0 : acc_re_q) + sum_re;
         acc_im_d = (s1_first_q ? '0 : acc_im_q) + sum_im;
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               len_d      = len_eff;
               conj_d     = cfg_conj_i;
               cnt_d      = LEN_W'(1);
               s1_valid_d = 1'b1;
               s1_first_d = 1'b1;
               if (len_eff == LEN_W'(1)) begin
                  s1_last_d = 1'b1;
                  state_d   = DRAIN;
               end else begin
                  state_d   = ACCUM;
               end
            end
         end
         ACCUM: begin
            if (accept) begin
               cnt_d      = cnt_inc;
               s1_valid_d = 1'b1;
               if (cnt_inc == len_q) begin
                  s1_last_d = 1'b1;
                  state_d   = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (s2_last_q) begin
               state_d     = OUTPUT;
               out_valid_d = 1'b1;
               res_re_d    = acc_re_q;
               res_im_d    = acc_im_q;
            end
         end
         OUTPUT: begin
            if (out_ready_i) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (flush_i) begin
         state_d     = IDLE;
         cnt_d       = '0;
         s1_valid_d  = 1'b0;
         s1_first_d  = 1'b0;
         s1_last_d   = 1'b0;
         s2_last_d   = 1'b0;
         out_valid_d = 1'b0;
         acc_re_d    = '0;
         acc_im_d    = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         conj_q      <= CONJ_OFF;
         s1_valid_q  <= 1'b0;
         s1_first_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s2_last_q   <= 1'b0;
         out_valid_q <= 1'b0;
         acc_re_q    <= '0;
         acc_im_q    <= '0;
         res_re_q    <= '0;
         res_im_q    <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         conj_q      <= conj_d;
         s1_valid_q  <= s1_valid_d;
         s1_first_q  <= s1_first_d;
         s1_last_q   <= s1_last_d;
         s2_last_q   <= s2_last_d;
         out_valid_q <= out_valid_d;
         acc_re_q    <= acc_re_d;
         acc_im_q    <= acc_im_d;
         res_re_q    <= res_re_d;
         res_im_q    <= res_im_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: the S1 lane array is plain flops rather than a RAM, so it is reset like any register.
         for (int l = 0; l < LANES; l++) begin
            s1_re_q[l] <= '0;
            s1_im_q[l] <= '0;
         end
      end else if (accept) begin
         for (int l = 0; l < LANES; l++) begin
            s1_re_q[l] <= lane_re[l];
            s1_im_q[l] <= lane_im[l];
         end
      end
   end

endmodule

// File: tb/tb_cplx_dot_stream.sv
// Randomized and directed bench for cplx_dot_stream against a plain-arithmetic complex dot-product model.
module tb_cplx_dot_stream;

   localparam int DATA_W    = 16;
   localparam int LANES     = 4;
   localparam int MAX_BEATS = 64;
   localparam int LEN_W     = $clog2(MAX_BEATS + 1);
   localparam int ACC_W     = 2 * DATA_W + 2 + $clog2(LANES) + $clog2(MAX_BEATS);

   logic                    clk_i = 1'b0;
   logic                    rst_ni;
   logic                    flush_i;
   logic [LEN_W-1:0]        cfg_len_i;
   logic                    cfg_conj_i;
   logic                    in_valid_i;
   logic                    in_ready_o;
   logic [LANES*DATA_W-1:0] a_re_i, a_im_i, b_re_i, b_im_i;
   logic                    out_valid_o;
   logic                    out_ready_i;
   logic [ACC_W-1:0]        result_re_o, result_im_o;
   logic                    busy_o;

   int total = 0;
   int bad   = 0;

   int op_ar [MAX_BEATS][LANES];
   int op_ai [MAX_BEATS][LANES];
   int op_br [MAX_BEATS][LANES];
   int op_bi [MAX_BEATS][LANES];

   longint got_re, got_im;

   always #5 clk_i = ~clk_i;

   cplx_dot_stream #(
      .DATA_W    (DATA_W),
      .LANES     (LANES),
      .MAX_BEATS (MAX_BEATS)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .cfg_len_i   (cfg_len_i),
      .cfg_conj_i  (cfg_conj_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .a_re_i      (a_re_i),
      .a_im_i      (a_im_i),
      .b_re_i      (b_re_i),
      .b_im_i      (b_im_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .result_re_o (result_re_o),
      .result_im_o (result_im_o),
      .busy_o      (busy_o)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic int rnd16();
      return int'($signed(16'($urandom)));
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic scramble();
      a_re_i = {LANES{16'($urandom)}};
      a_im_i = {LANES{16'($urandom)}};
      b_re_i = {LANES{16'($urandom)}};
      b_im_i = {LANES{16'($urandom)}};
   endtask

   // Patterns: 0 random, 1 a=(1,2) b=(3,4), 2 all -32768, 3 lane0 a=(5,0) b=(0,1) else zero.
   task automatic fill(input int len, input int pattern);
      for (int b = 0; b < len; b++) begin
         for (int l = 0; l < LANES; l++) begin
            case (pattern)
               1: begin op_ar[b][l] = 1; op_ai[b][l] = 2; op_br[b][l] = 3; op_bi[b][l] = 4; end
               2: begin op_ar[b][l] = -32768; op_ai[b][l] = -32768; op_br[b][l] = -32768; op_bi[b][l] = -32768; end
               3: begin
                  op_ar[b][l] = (l == 0) ? 5 : 0;
                  op_ai[b][l] = 0;
                  op_br[b][l] = 0;
                  op_bi[b][l] = (l == 0) ? 1 : 0;
               end
               default: begin
                  op_ar[b][l] = rnd16(); op_ai[b][l] = rnd16();
                  op_br[b][l] = rnd16(); op_bi[b][l] = rnd16();
               end
            endcase
         end
      end
   endtask

   // Conjugation is modelled as negating b's imaginary part before an ordinary complex product.
   task automatic model(input int len, input bit conj, output longint re, output longint im);
      longint ar, ai, br, bi;
      re = 0;
      im = 0;
      for (int b = 0; b < len; b++) begin
         for (int l = 0; l < LANES; l++) begin
            ar = op_ar[b][l];
            ai = op_ai[b][l];
            br = op_br[b][l];
            bi = conj ? -longint'(op_bi[b][l]) : longint'(op_bi[b][l]);
            re += ar * br - ai * bi;
            im += ar * bi + ai * br;
         end
      end
   endtask

   task automatic drive_beat(input int b);
      for (int l = 0; l < LANES; l++) begin
         a_re_i[l*DATA_W +: DATA_W] = 16'(op_ar[b][l]);
         a_im_i[l*DATA_W +: DATA_W] = 16'(op_ai[b][l]);
         b_re_i[l*DATA_W +: DATA_W] = 16'(op_br[b][l]);
         b_im_i[l*DATA_W +: DATA_W] = 16'(op_bi[b][l]);
      end
   endtask

   // Later beats carry junk config to show it is ignored mid-vector.
   task automatic feed(input int cfg_len, input bit conj, input int nbeats,
                       input int bubble_pct, input int bubble_at);
      for (int b = 0; b < nbeats; b++) begin
         if (b > 0 && (b == bubble_at || $urandom_range(0, 99) < bubble_pct)) begin
            in_valid_i = 1'b0;
            scramble();
            tick();
         end
         drive_beat(b);
         in_valid_i = 1'b1;
         cfg_len_i  = (b == 0) ? LEN_W'(cfg_len) : LEN_W'($urandom);
         cfg_conj_i = (b == 0) ? conj : 1'($urandom);
         check("in_ready during feed", in_ready_o, 1);
         tick();
      end
      in_valid_i = 1'b0;
      scramble();
   endtask

   task automatic wait_result(input string tag);
      int n = 0;
      while (!out_valid_o && n < 200) begin
         tick();
         n++;
      end
      check({tag, " latency"}, n, 2);
      check({tag, " in_ready low"}, in_ready_o, 0);
      check({tag, " busy"}, busy_o, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " in_ready"}, in_ready_o, 1);
      check({tag, " out_valid"}, out_valid_o, 0);
      check({tag, " busy"}, busy_o, 0);
      check({tag, " result_re"}, longint'($signed(result_re_o)), 0);
      check({tag, " result_im"}, longint'($signed(result_im_o)), 0);
   endtask

   // finish_mode: 0 handshake, 1 flush instead of handshake, 2 reset while OUTPUT.
   task automatic run_vector(input string tag, input int cfg_len, input bit conj, input int pattern,
                             input int hold, input int bubble_pct, input int bubble_at,
                             input int finish_mode);
      int     eff;
      longint exp_re, exp_im;
      eff = (cfg_len == 0) ? 1 : ((cfg_len > MAX_BEATS) ? MAX_BEATS : cfg_len);
      fill(eff, pattern);
      model(eff, conj, exp_re, exp_im);
      out_ready_i = 1'b0;
      feed(cfg_len, conj, eff, bubble_pct, bubble_at);
      wait_result(tag);
      got_re = longint'($signed(result_re_o));
      got_im = longint'($signed(result_im_o));
      check({tag, " re"}, got_re, exp_re);
      check({tag, " im"}, got_im, exp_im);
      for (int h = 0; h < hold; h++) begin
         tick();
         check({tag, " hold valid"}, out_valid_o, 1);
         check({tag, " hold ready"}, in_ready_o, 0);
         check({tag, " hold re"}, longint'($signed(result_re_o)), exp_re);
         check({tag, " hold im"}, longint'($signed(result_im_o)), exp_im);
      end
      case (finish_mode)
         1: begin
            flush_i     = 1'b1;
            out_ready_i = 1'($urandom);
            tick();
            flush_i     = 1'b0;
            out_ready_i = 1'b0;
            check({tag, " flush valid"}, out_valid_o, 0);
            check({tag, " flush busy"}, busy_o, 0);
         end
         2: begin
            #2 rst_ni = 1'b0;
            #1 check_reset_outputs({tag, " rst in OUTPUT"});
            @(negedge clk_i);
            rst_ni = 1'b1;
            tick();
         end
         default: begin
            out_ready_i = 1'b1;
            tick();
            out_ready_i = 1'b0;
            check({tag, " post valid"}, out_valid_o, 0);
            check({tag, " post ready"}, in_ready_o, 1);
            check({tag, " post busy"}, busy_o, 0);
            check({tag, " post re held"}, longint'($signed(result_re_o)), exp_re);
         end
      endcase
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      rst_ni      = 1'b0;
      flush_i     = 1'b0;
      cfg_len_i   = '0;
      cfg_conj_i  = 1'b0;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      scramble();
      tick();
      tick();
      check_reset_outputs("reset");
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();

      run_vector("t1 normal", 1, 1'b0, 1, 0, 0, -1, 0);
      check("t1 re const", got_re, -20);
      check("t1 im const", got_im, 40);

      run_vector("t2 conj", 1, 1'b1, 1, 0, 0, -1, 0);
      check("t2 re const", got_re, 44);
      check("t2 im const", got_im, 8);

      run_vector("t3 fullscale", 64, 1'b0, 2, 0, 0, -1, 0);
      check("t3 re const", got_re, 0);
      check("t3 im const", got_im, 64'sd549755813888);

      run_vector("len0 as 1", 0, 1'b0, 0, 0, 0, -1, 0);
      run_vector("len clamp", 100, 1'b1, 0, 0, 0, -1, 0);

      run_vector("t4 bubble hold", 3, 1'b0, 0, 5, 0, 2, 0);
      run_vector("t4 next", 2, 1'b1, 0, 0, 0, -1, 0);

      // Flush after two beats of a four-beat vector, with a third beat presented in the flush cycle.
      fill(4, 0);
      feed(4, 1'b0, 2, 0, -1);
      drive_beat(2);
      in_valid_i = 1'b1;
      flush_i    = 1'b1;
      tick();
      flush_i    = 1'b0;
      in_valid_i = 1'b0;
      check("t5 flush busy", busy_o, 0);
      check("t5 flush ready", in_ready_o, 1);
      tick();
      tick();
      tick();
      check("t5 no stale valid", out_valid_o, 0);
      run_vector("t5 after flush", 1, 1'b0, 3, 0, 0, -1, 0);
      check("t5 re const", got_re, 0);
      check("t5 im const", got_im, 5);

      fill(5, 0);
      feed(5, 1'b0, 2, 0, -1);
      #2 rst_ni = 1'b0;
      #1 check_reset_outputs("t6 rst in ACCUM");
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();
      tick();
      check("t6 no partial", out_valid_o, 0);
      run_vector("t6 rst in OUTPUT", 3, 1'b1, 0, 1, 0, -1, 2);
      run_vector("t6 after rst", 2, 1'b0, 0, 0, 0, -1, 0);
      run_vector("flush in OUTPUT", 2, 1'b0, 0, 0, 0, -1, 1);
      run_vector("after out flush", 1, 1'b1, 0, 0, 0, -1, 0);

      for (int v = 0; v < 1000; v++) begin
         len = ($urandom_range(0, 19) == 0) ? $urandom_range(60, 127) : $urandom_range(0, 16);
         run_vector("rand", len, 1'($urandom), 0, $urandom_range(0, 2), 20, -1,
                    ($urandom_range(0, 9) == 0) ? 1 : 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
